// File: rtl/amstrad_tape_pkg.sv
// Shared state encodings and word-format constants for the tape player.
package amstrad_tape_pkg;

   typedef enum logic [2:0] {
      P_STOP,
      P_LO,
      P_HI,
      P_RUN,
      P_END
   } pulse_state_t;

   typedef enum logic {
      F_IDLE,
      F_REQ
   } fetch_state_t;

   localparam int WORD_PAUSE_BIT = 15;
   localparam int WORD_COUNT_W   = 15;

endpackage

// File: rtl/amstrad_tape_player_if.sv
// Byte read port from the tape player into the SDRAM arbiter.
interface amstrad_tape_player_if #(parameter int ADDR_W = 25);

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [7:0]        mem_din;

   modport master (output mem_req, output mem_addr, input mem_ack, input mem_din);
   modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_din);

endinterface

// File: rtl/amstrad_tape_fifo.sv
// Small synchronous byte FIFO with first-word fall-through output and flush.
module amstrad_tape_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flush,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [7:0]     mem_reg [DEPTH];
   logic [PTR_W:0] wr_ptr_reg;
   logic [PTR_W:0] rd_ptr_reg;
   logic           do_push;
   logic           do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                    (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_reg[rd_ptr_reg[PTR_W-1:0]];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_reg[wr_ptr_reg[PTR_W-1:0]] <= din;
   end

endmodule

// File: rtl/amstrad_tape_player.sv
// Streams a pulse-duration tape image from SDRAM and drives the motherboard tape_in level.
module amstrad_tape_player
   import amstrad_tape_pkg::*;
#(
   parameter int ADDR_W      = 25,
   parameter int FIFO_DEPTH  = 8,
   parameter int PAUSE_SHIFT = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce_4,
   input  logic                  tape_motor,
   input  logic                  tape_play,
   input  logic                  tape_rewind,
   input  logic                  tape_ready,
   input  logic [ADDR_W-1:0]     tape_size,
   amstrad_tape_player_if.master mem,
   output logic                  tape_in,
   output logic                  tape_active,
   output logic [ADDR_W-1:0]     tape_pos
);

   localparam int CNT_W = WORD_COUNT_W + PAUSE_SHIFT;

   fetch_state_t      f_state_reg, f_state_next;
   pulse_state_t      p_state_reg, p_state_next;
   logic [ADDR_W-1:0] addr_reg;
   logic              discard_reg;
   logic [ADDR_W-1:0] size_even;
   logic              bytes_left;
   logic              flush;
   logic              tick;

   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]        fifo_dout;

   logic [7:0]        lo_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              pause_reg;
   logic              tape_in_reg;
   logic [ADDR_W-1:0] tape_pos_reg;

   logic [15:0]       word_next;
   logic [CNT_W-1:0]  load_raw, load_cnt;

   assign flush      = tape_rewind || !tape_ready;
   assign tick       = ce_4 && tape_motor && tape_play;
   // A trailing odd byte can never form a word, so it is never fetched.
   assign size_even  = tape_size & ~ADDR_W'(1);
   assign bytes_left = (addr_reg < size_even);
   assign fifo_push  = (f_state_reg == F_REQ) && mem.mem_ack && !discard_reg && !flush;

   amstrad_tape_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (fifo_push),
      .din   (mem.mem_din),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // ---------------- fetch FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) f_state_reg <= F_IDLE;
      else       f_state_reg <= f_state_next;
   end

   always_comb begin
      f_state_next = f_state_reg;
      case (f_state_reg)
         F_IDLE:  if (!flush && !fifo_full && bytes_left) f_state_next = F_REQ;
         F_REQ:   if (mem.mem_ack) f_state_next = F_IDLE;
         default: f_state_next = F_IDLE;
      endcase
   end

   always_comb begin
      mem.mem_req = (f_state_reg == F_REQ);
   end

   assign mem.mem_addr = addr_reg;

   // A rewind during an outstanding request keeps the address stable until the
   // ack arrives; the returned byte is dropped and the address then restarts at 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_reg    <= '0;
         discard_reg <= 1'b0;
      end else if (flush) begin
         if (f_state_reg == F_REQ && !mem.mem_ack) begin
            discard_reg <= 1'b1;
         end else begin
            addr_reg    <= '0;
            discard_reg <= 1'b0;
         end
      end else if (f_state_reg == F_REQ && mem.mem_ack) begin
         if (discard_reg) begin
            addr_reg    <= '0;
            discard_reg <= 1'b0;
         end else begin
            addr_reg <= addr_reg + 1'b1;
         end
      end
   end

   // ---------------- pulse FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) p_state_reg <= P_STOP;
      else       p_state_reg <= p_state_next;
   end

   always_comb begin
      p_state_next = p_state_reg;
      if (flush) begin
         p_state_next = P_STOP;
      end else begin
         case (p_state_reg)
            P_STOP: p_state_next = P_LO;
            P_LO: begin
               if (!fifo_empty)                     p_state_next = P_HI;
               else if (!bytes_left && !discard_reg) p_state_next = P_END;
            end
            P_HI:    if (!fifo_empty) p_state_next = P_RUN;
            P_RUN:   if (tick && cnt_reg == CNT_W'(1)) p_state_next = P_LO;
            P_END:   p_state_next = P_END;
            default: p_state_next = P_STOP;
         endcase
      end
   end

   always_comb begin
      tape_active = (p_state_reg == P_RUN);
      fifo_pop    = (p_state_reg == P_LO || p_state_reg == P_HI) && !fifo_empty && !flush;
   end

   // Word count of zero still lasts one tick.
   always_comb begin
      word_next = {fifo_dout, lo_reg};
      load_raw  = CNT_W'(word_next[WORD_COUNT_W-1:0]);
      if (word_next[WORD_PAUSE_BIT]) load_raw = load_raw << PAUSE_SHIFT;
      load_cnt  = (load_raw == '0) ? CNT_W'(1) : load_raw;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lo_reg       <= '0;
         cnt_reg      <= '0;
         pause_reg    <= 1'b0;
         tape_in_reg  <= 1'b0;
         tape_pos_reg <= '0;
      end else if (flush) begin
         tape_in_reg  <= 1'b0;
         tape_pos_reg <= '0;
      end else begin
         case (p_state_reg)
            P_LO: if (!fifo_empty) lo_reg <= fifo_dout;
            P_HI: begin
               if (!fifo_empty) begin
                  cnt_reg      <= load_cnt;
                  pause_reg    <= word_next[WORD_PAUSE_BIT];
                  tape_pos_reg <= tape_pos_reg + ADDR_W'(2);
                  if (word_next[WORD_PAUSE_BIT]) tape_in_reg <= 1'b0;
               end
            end
            P_RUN: begin
               if (tick) begin
                  if (cnt_reg == CNT_W'(1)) begin
                     if (!pause_reg) tape_in_reg <= ~tape_in_reg;
                  end else begin
                     cnt_reg <= cnt_reg - 1'b1;
                  end
               end
            end
            P_END:   tape_in_reg <= 1'b0;
            default: ;
         endcase
      end
   end

   assign tape_in  = tape_in_reg;
   assign tape_pos = tape_pos_reg;

endmodule

// File: tb/tb_amstrad_tape_player.sv
// Directed bench for amstrad_tape_player: SDRAM byte responder, tick counter and level checks.
module tb_amstrad_tape_player;

   localparam int ADDR_W = 25;

   logic              clk = 1'b0;
   logic              reset;
   logic              ce_4 = 1'b0;
   logic              tape_motor, tape_play, tape_rewind, tape_ready;
   logic [ADDR_W-1:0] tape_size;
   logic              tape_in, tape_active;
   logic [ADDR_W-1:0] tape_pos;

   amstrad_tape_player_if #(.ADDR_W(ADDR_W)) mem_if ();

   amstrad_tape_player #(
      .ADDR_W      (ADDR_W),
      .FIFO_DEPTH  (8),
      .PAUSE_SHIFT (10)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ce_4        (ce_4),
      .tape_motor  (tape_motor),
      .tape_play   (tape_play),
      .tape_rewind (tape_rewind),
      .tape_ready  (tape_ready),
      .tape_size   (tape_size),
      .mem         (mem_if),
      .tape_in     (tape_in),
      .tape_active (tape_active),
      .tape_pos    (tape_pos)
   );

   always #5 clk = ~clk;

   // ce_4 is one clock in eight; tick_cnt counts the same edges the DUT sees.
   logic [2:0] ce_div = '0;
   int         tick_cnt = 0;
   always @(posedge clk) begin
      ce_div <= ce_div + 3'd1;
      ce_4   <= (ce_div == 3'd7);
      if (ce_4) tick_cnt <= tick_cnt + 1;
   end

   logic [7:0] img [32];
   int         ack_delay = 0;
   int         wait_cnt  = 0;
   always @(posedge clk) begin
      if (reset) begin
         mem_if.mem_ack <= 1'b0;
         mem_if.mem_din <= 8'h00;
         wait_cnt       <= 0;
      end else begin
         mem_if.mem_ack <= 1'b0;
         if (mem_if.mem_req && !mem_if.mem_ack) begin
            if (wait_cnt >= ack_delay) begin
               mem_if.mem_ack <= 1'b1;
               mem_if.mem_din <= img[mem_if.mem_addr[4:0]];
               wait_cnt       <= 0;
            end else begin
               wait_cnt <= wait_cnt + 1;
            end
         end
      end
   end

   // Edge monitor: counts tape_in transitions and zero-tick-wide pulses.
   int   edge_cnt = 0, zero_width = 0, last_edge_tick = -1;
   logic last_level = 1'b0;
   always @(negedge clk) begin
      if (tape_in !== last_level) begin
         edge_cnt = edge_cnt + 1;
         if (tick_cnt == last_edge_tick) zero_width = zero_width + 1;
         last_edge_tick = tick_cnt;
      end
      last_level = tape_in;
   end

   int pass_cnt = 0, total_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic wait_level(input logic lvl, input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (tape_in === lvl) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_active(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (tape_active === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_tick(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (tick_cnt == target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic restart(input int size);
      tape_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tape_size  = ADDR_W'(size);
      tape_ready = 1'b1;
   endtask

   bit ok;
   int t0, t1, e0, z0;

   initial begin
      for (int i = 0; i < 32; i++) img[i] = 8'h00;
      reset = 1'b1; tape_motor = 1'b1; tape_play = 1'b1;
      tape_rewind = 1'b0; tape_ready = 1'b0; tape_size = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_mem_req", mem_if.mem_req, 0);
      check("rst_mem_addr", mem_if.mem_addr, 0);
      check("rst_tape_in", tape_in, 0);
      check("rst_active", tape_active, 0);
      check("rst_pos", tape_pos, 0);

      // Two 16-tick words, then end of tape.
      img[0] = 8'h10; img[1] = 8'h00; img[2] = 8'h10; img[3] = 8'h00;
      restart(4);
      wait_active(200, ok);
      check("t1_active_seen", ok, 1);
      t0 = tick_cnt;
      wait_level(1'b1, 300, ok);
      check("t1_rise_width", tick_cnt - t0, 16);
      t0 = tick_cnt;
      wait_level(1'b0, 300, ok);
      check("t1_fall_width", tick_cnt - t0, 16);
      repeat (20) @(negedge clk);
      check("t1_end_tape_in", tape_in, 0);
      check("t1_end_active", tape_active, 0);
      check("t1_end_pos", tape_pos, 4);
      check("t1_end_req", mem_if.mem_req, 0);
      check("t1_end_addr", mem_if.mem_addr, 4);

      // 5-tick toggle, pause 0x8002 (2048 ticks, forced low), then 3-tick toggle.
      img[0] = 8'h05; img[1] = 8'h00; img[2] = 8'h02; img[3] = 8'h80;
      img[4] = 8'h03; img[5] = 8'h00;
      restart(6);
      wait_level(1'b1, 400, ok);
      check("t2_rise_seen", ok, 1);
      t1 = tick_cnt;
      wait_level(1'b0, 10, ok);
      check("t2_pause_drives_low", ok, 1);
      check("t2_pause_low_delay", tick_cnt - t1, 0);
      wait_level(1'b1, 2100 * 8, ok);
      check("t2_pause_plus_word", tick_cnt - t1, 2051);

      // 100-tick word with the motor stopped for 500 ticks in the middle.
      img[0] = 8'h64; img[1] = 8'h00; img[2] = 8'h64; img[3] = 8'h00;
      restart(4);
      wait_active(200, ok);
      t0 = tick_cnt;
      wait_tick(t0 + 30, ok);
      tape_motor = 1'b0;
      wait_tick(t0 + 530, ok);
      check("t3_frozen_level", tape_in, 0);
      check("t3_frozen_active", tape_active, 1);
      tape_motor = 1'b1;
      wait_level(1'b1, 200 * 8, ok);
      check("t3_total_width", tick_cnt - t0, 600);

      // Slow memory with 1-tick words: FIFO underruns, level must hold.
      for (int i = 0; i < 8; i++) img[i] = 8'h00;
      ack_delay = 40;
      restart(8);
      e0 = edge_cnt; z0 = zero_width;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (tape_pos == ADDR_W'(8)) break;
      end
      repeat (40) @(negedge clk);
      check("t4_edges", edge_cnt - e0, 4);
      check("t4_no_glitch", zero_width - z0, 0);
      check("t4_pos", tape_pos, 8);
      check("t4_tape_in", tape_in, 0);

      // Rewind in the same cycle as the ack for address 5.
      for (int i = 0; i < 10; i += 2) begin
         img[i] = 8'h40; img[i+1] = 8'h00;
      end
      ack_delay = 3;
      restart(10);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (mem_if.mem_ack === 1'b1 && mem_if.mem_addr == ADDR_W'(5)) begin
            ok = 1'b1;
            break;
         end
      end
      check("t5_ack_at_5", ok, 1);
      check("t5_pos_before", tape_pos, 2);
      tape_rewind = 1'b1;
      @(negedge clk);
      tape_rewind = 1'b0;
      check("t5_addr_zero", mem_if.mem_addr, 0);
      check("t5_pos_zero", tape_pos, 0);
      check("t5_tape_in", tape_in, 0);
      check("t5_req_dropped", mem_if.mem_req, 0);
      @(negedge clk);
      check("t5_rereq", mem_if.mem_req, 1);
      check("t5_rereq_addr", mem_if.mem_addr, 0);

      // Odd length: byte 4 is never a word.
      img[0] = 8'h02; img[1] = 8'h00; img[2] = 8'h02; img[3] = 8'h00; img[4] = 8'hAA;
      ack_delay = 0;
      restart(5);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (tape_pos == ADDR_W'(4) && tape_active === 1'b0) break;
      end
      repeat (100) @(negedge clk);
      check("t6_pos", tape_pos, 4);
      check("t6_active", tape_active, 0);
      check("t6_tape_in", tape_in, 0);
      check("t6_req", mem_if.mem_req, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
